// File: rtl/cache_ri.sv
// Refill/IO engine behind the cache front end: burst line refills into the data/tag RAMs
// and single uncached bus transfers, both acknowledged with a one-cycle cmd_ready pulse.
module cache_ri #(
  parameter int SIZE            = 8192,
  parameter int DATA_ADDR_WIDTH = $clog2(SIZE / 16),
  parameter int TAG_ADDR_WIDTH  = 32 - (DATA_ADDR_WIDTH + 2)
) (
  input  logic                         clk,
  input  logic                         rest,
  input  logic [3:0]                   cmd,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [31:0]                  req_address,
  input  logic [3:0]                   req_byteEnable,
  input  logic                         req_read,
  input  logic                         req_write,
  input  logic [31:0]                  req_writeData,
  input  logic [1:0]                   fill_way,
  output logic [31:0]                  rsp_readData,
  output logic                         rsp_readDataValid,
  output logic [31:0]                  m1_address,
  output logic [3:0]                   m1_byteEnable,
  output logic                         m1_read,
  output logic                         m1_write,
  output logic [31:0]                  m1_writeData,
  output logic [2:0]                   m1_burstCount,
  input  logic                         m1_waitRequest,
  input  logic [31:0]                  m1_readData,
  input  logic                         m1_readDataValid,
  output logic [DATA_ADDR_WIDTH-1:0]   data_wAddr,
  output logic [1:0]                   data_wWay,
  output logic [31:0]                  data_wData,
  output logic                         data_wEn,
  output logic [3:0]                   data_wByteEn,
  output logic [DATA_ADDR_WIDTH-3:0]   tag_wAddr,
  output logic [1:0]                   tag_wWay,
  output logic [31:0]                  tag_wData,
  output logic                         tag_wEn
);

  typedef enum logic [2:0] {IDLE, RB_REQ, RB_DATA, TAG_WR, IO_REQ, IO_WAIT, DONE} stateT;

  localparam logic [3:0] CMD_RB   = 4'h1;
  localparam logic [3:0] CMD_IORW = 4'h2;

  stateT       state, stateNext;
  logic [1:0]  beat;
  logic [3:0]  cmdQ;
  logic [31:0] addrQ;
  logic [3:0]  byteEnQ;
  logic        readQ;
  logic        writeQ;
  logic [31:0] writeDataQ;
  logic [1:0]  wayQ;
  logic [31:0] rspData;
  logic [31:0] mergeData;
  logic        criticalBeat;

  assign criticalBeat = (beat == addrQ[3:2]);
  assign rsp_readData = rspData;

  always_ff @(posedge clk) begin
    if (rest) begin
      state      <= IDLE;
      beat       <= '0;
      cmdQ       <= '0;
      addrQ      <= '0;
      byteEnQ    <= '0;
      readQ      <= 1'b0;
      writeQ     <= 1'b0;
      writeDataQ <= '0;
      wayQ       <= '0;
      rspData    <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && cmd_valid) begin
        cmdQ       <= cmd;
        addrQ      <= req_address;
        byteEnQ    <= req_byteEnable;
        readQ      <= req_read;
        writeQ     <= req_write;
        writeDataQ <= req_writeData;
        wayQ       <= fill_way;
      end
      if (state == RB_REQ) begin
        beat <= '0;
      end
      // The requester's word is captured as it streams past, whatever its position in the burst
      if (state == RB_DATA && m1_readDataValid) begin
        beat <= beat + 2'd1;
        if (readQ && criticalBeat) begin
          rspData <= m1_readData;
        end
      end
      if (state == IO_WAIT && m1_readDataValid) begin
        rspData <= m1_readData;
      end
    end
  end

  always_comb begin
    mergeData = m1_readData;
    for (int i = 0; i < 4; i++) begin
      if (byteEnQ[i]) begin
        mergeData[8*i +: 8] = writeDataQ[8*i +: 8];
      end
    end
  end

  always_comb begin
    stateNext         = state;
    cmd_ready         = 1'b0;
    rsp_readDataValid = 1'b0;
    m1_address        = '0;
    m1_byteEnable     = '0;
    m1_read           = 1'b0;
    m1_write          = 1'b0;
    m1_writeData      = '0;
    m1_burstCount     = '0;
    data_wAddr        = '0;
    data_wWay         = '0;
    data_wData        = '0;
    data_wEn          = 1'b0;
    data_wByteEn      = '0;
    tag_wAddr         = '0;
    tag_wWay          = '0;
    tag_wData         = '0;
    tag_wEn           = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_RB:   stateNext = RB_REQ;
            CMD_IORW: stateNext = IO_REQ;
            default:  stateNext = DONE;
          endcase
        end
      end
      RB_REQ: begin
        m1_read       = 1'b1;
        m1_address    = {addrQ[31:4], 4'h0};
        m1_burstCount = 3'd4;
        m1_byteEnable = 4'hF;
        if (!m1_waitRequest) begin
          stateNext = RB_DATA;
        end
      end
      RB_DATA: begin
        if (m1_readDataValid) begin
          data_wEn     = 1'b1;
          data_wAddr   = {addrQ[DATA_ADDR_WIDTH+1:4], beat};
          data_wWay    = wayQ;
          data_wByteEn = 4'hF;
          data_wData   = (writeQ && criticalBeat) ? mergeData : m1_readData;
          if (beat == 2'd3) begin
            stateNext = TAG_WR;
          end
        end
      end
      TAG_WR: begin
        tag_wEn                          = 1'b1;
        tag_wAddr                        = addrQ[DATA_ADDR_WIDTH+1:4];
        tag_wWay                         = wayQ;
        tag_wData[TAG_ADDR_WIDTH]        = 1'b1;
        tag_wData[TAG_ADDR_WIDTH-1:0]    = addrQ[31:DATA_ADDR_WIDTH+2];
        stateNext                        = DONE;
      end
      IO_REQ: begin
        // A request with neither read nor write set completes without touching the bus
        if (!readQ && !writeQ) begin
          stateNext = DONE;
        end else begin
          m1_address    = addrQ;
          m1_byteEnable = byteEnQ;
          m1_burstCount = 3'd1;
          m1_read       = readQ;
          m1_write      = writeQ;
          m1_writeData  = writeDataQ;
          if (!m1_waitRequest) begin
            stateNext = readQ ? IO_WAIT : DONE;
          end
        end
      end
      IO_WAIT: begin
        if (m1_readDataValid) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        cmd_ready         = 1'b1;
        rsp_readDataValid = readQ && (cmdQ == CMD_RB || cmdQ == CMD_IORW);
        stateNext         = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ri.sv
// Directed bench for cache_ri: inputs change on the falling edge, outputs are checked
// just after, so each check sees the combinational outputs of the current cycle.
module tb_cache_ri;

  logic        clk = 1'b0;
  logic        rest;
  logic [3:0]  cmd;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] req_address;
  logic [3:0]  req_byteEnable;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_writeData;
  logic [1:0]  fill_way;
  logic [31:0] rsp_readData;
  logic        rsp_readDataValid;
  logic [31:0] m1_address;
  logic [3:0]  m1_byteEnable;
  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_writeData;
  logic [2:0]  m1_burstCount;
  logic        m1_waitRequest;
  logic [31:0] m1_readData;
  logic        m1_readDataValid;
  logic [8:0]  data_wAddr;
  logic [1:0]  data_wWay;
  logic [31:0] data_wData;
  logic        data_wEn;
  logic [3:0]  data_wByteEn;
  logic [6:0]  tag_wAddr;
  logic [1:0]  tag_wWay;
  logic [31:0] tag_wData;
  logic        tag_wEn;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_ri dut (
    .clk(clk), .rest(rest), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .req_address(req_address), .req_byteEnable(req_byteEnable), .req_read(req_read),
    .req_write(req_write), .req_writeData(req_writeData), .fill_way(fill_way),
    .rsp_readData(rsp_readData), .rsp_readDataValid(rsp_readDataValid),
    .m1_address(m1_address), .m1_byteEnable(m1_byteEnable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writeData(m1_writeData), .m1_burstCount(m1_burstCount),
    .m1_waitRequest(m1_waitRequest), .m1_readData(m1_readData),
    .m1_readDataValid(m1_readDataValid), .data_wAddr(data_wAddr), .data_wWay(data_wWay),
    .data_wData(data_wData), .data_wEn(data_wEn), .data_wByteEn(data_wByteEn),
    .tag_wAddr(tag_wAddr), .tag_wWay(tag_wWay), .tag_wData(tag_wData), .tag_wEn(tag_wEn)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] addr, input logic rd,
                               input logic wr, input logic [3:0] be, input logic [31:0] wd,
                               input logic [1:0] way);
    cmd            = c;
    cmd_valid      = 1'b1;
    req_address    = addr;
    req_read       = rd;
    req_write      = wr;
    req_byteEnable = be;
    req_writeData  = wd;
    fill_way       = way;
  endtask

  task automatic memDrive(input logic stall, input logic rdv, input logic [31:0] rdata);
    m1_waitRequest   = stall;
    m1_readDataValid = rdv;
    m1_readData      = rdata;
  endtask

  // Scramble the request inputs so any path that bypasses the latched copy shows up
  task automatic scrambleRequest();
    cmd            = 4'h3;
    req_address    = 32'hFFFF_FFF0;
    req_byteEnable = 4'h0;
    req_read       = ~req_read;
    req_write      = ~req_write;
    req_writeData  = 32'h5555_5555;
    fill_way       = 2'd0;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] beats [4];

    rest = 1'b1;
    cmd = '0; cmd_valid = 1'b0; req_address = '0; req_byteEnable = '0;
    req_read = 1'b0; req_write = 1'b0; req_writeData = '0; fill_way = '0;
    memDrive(1'b0, 1'b0, 32'h0);
    nextCycle(); nextCycle();
    rest = 1'b0;
    settle();
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'h0);
    checkOutput("reset_m1_read", 32'(m1_read), 32'h0);
    checkOutput("reset_data_wEn", 32'(data_wEn), 32'h0);
    checkOutput("reset_tag_wEn", 32'(tag_wEn), 32'h0);
    checkOutput("reset_rsp_readData", rsp_readData, 32'h0);
    checkOutput("reset_m1_address", m1_address, 32'h0);

    // Read miss at 0x1238 into way 2; the critical word is beat 2
    beats = '{32'h11, 32'h22, 32'h33, 32'h44};
    nextCycle();
    applyStimulus(4'h1, 32'h0000_1238, 1'b1, 1'b0, 4'hF, 32'h0, 2'd2);
    settle();
    checkOutput("rbr_c0_m1_read", 32'(m1_read), 32'h0);
    nextCycle();
    scrambleRequest();
    settle();
    checkOutput("rbr_m1_read", 32'(m1_read), 32'h1);
    checkOutput("rbr_m1_address", m1_address, 32'h0000_1230);
    checkOutput("rbr_m1_burstCount", 32'(m1_burstCount), 32'h4);
    checkOutput("rbr_m1_byteEnable", 32'(m1_byteEnable), 32'hF);
    for (int b = 0; b < 4; b++) begin
      nextCycle();
      memDrive(1'b0, 1'b1, beats[b]);
      settle();
      checkOutput($sformatf("rbr_b%0d_m1_read", b), 32'(m1_read), 32'h0);
      checkOutput($sformatf("rbr_b%0d_wEn", b), 32'(data_wEn), 32'h1);
      checkOutput($sformatf("rbr_b%0d_wAddr", b), 32'(data_wAddr), 32'h8C + 32'(b));
      checkOutput($sformatf("rbr_b%0d_wData", b), data_wData, beats[b]);
      checkOutput($sformatf("rbr_b%0d_wWay", b), 32'(data_wWay), 32'h2);
      checkOutput($sformatf("rbr_b%0d_wByteEn", b), 32'(data_wByteEn), 32'hF);
    end
    nextCycle();
    memDrive(1'b0, 1'b1, 32'h99);
    settle();
    checkOutput("rbr_tag_wEn", 32'(tag_wEn), 32'h1);
    checkOutput("rbr_tag_extra_beat_wEn", 32'(data_wEn), 32'h0);
    checkOutput("rbr_tag_wAddr", 32'(tag_wAddr), 32'h23);
    checkOutput("rbr_tag_wData", tag_wData, 32'h0020_0002);
    checkOutput("rbr_tag_wWay", 32'(tag_wWay), 32'h2);
    nextCycle();
    memDrive(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rbr_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rbr_rsp_valid", 32'(rsp_readDataValid), 32'h1);
    checkOutput("rbr_rsp_data", rsp_readData, 32'h33);
    nextCycle();
    cmd_valid = 1'b0;
    settle();
    checkOutput("rbr_after_cmd_ready", 32'(cmd_ready), 32'h0);
    checkOutput("rbr_after_rsp_data", rsp_readData, 32'h33);

    // Write miss at 0x4 into way 1 with a one-cycle stall; beat 1 merges the low half-word
    beats = '{32'h1000_0000, 32'h1234_5678, 32'h3, 32'h4};
    nextCycle();
    applyStimulus(4'h1, 32'h0000_0004, 1'b0, 1'b1, 4'b0011, 32'hAAAA_BBBB, 2'd1);
    settle();
    nextCycle();
    memDrive(1'b1, 1'b0, 32'h0);
    scrambleRequest();
    settle();
    checkOutput("rbw_stall_m1_read", 32'(m1_read), 32'h1);
    nextCycle();
    memDrive(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rbw_accept_m1_read", 32'(m1_read), 32'h1);
    checkOutput("rbw_accept_m1_address", m1_address, 32'h0);
    for (int b = 0; b < 4; b++) begin
      nextCycle();
      memDrive(1'b0, 1'b1, beats[b]);
      settle();
      checkOutput($sformatf("rbw_b%0d_wAddr", b), 32'(data_wAddr), 32'(b));
      checkOutput($sformatf("rbw_b%0d_wData", b), data_wData, (b == 1) ? 32'h1234_BBBB : beats[b]);
      checkOutput($sformatf("rbw_b%0d_wWay", b), 32'(data_wWay), 32'h1);
    end
    nextCycle();
    memDrive(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("rbw_tag_wData", tag_wData, 32'h0020_0000);
    checkOutput("rbw_tag_wAddr", 32'(tag_wAddr), 32'h0);
    nextCycle();
    settle();
    checkOutput("rbw_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("rbw_rsp_valid", 32'(rsp_readDataValid), 32'h0);
    checkOutput("rbw_rsp_hold", rsp_readData, 32'h33);
    nextCycle();
    cmd_valid = 1'b0;

    // IO write with three stall cycles; request fields must hold steady throughout
    nextCycle();
    applyStimulus(4'h2, 32'h8000_0010, 1'b0, 1'b1, 4'hF, 32'hCAFE_F00D, 2'd0);
    settle();
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      memDrive(c < 3, 1'b1, 32'h7777_7777);
      if (c == 0) scrambleRequest();
      settle();
      checkOutput($sformatf("iow_c%0d_m1_write", c), 32'(m1_write), 32'h1);
      checkOutput($sformatf("iow_c%0d_m1_read", c), 32'(m1_read), 32'h0);
      checkOutput($sformatf("iow_c%0d_m1_address", c), m1_address, 32'h8000_0010);
      checkOutput($sformatf("iow_c%0d_m1_wdata", c), m1_writeData, 32'hCAFE_F00D);
      checkOutput($sformatf("iow_c%0d_m1_burst", c), 32'(m1_burstCount), 32'h1);
      checkOutput($sformatf("iow_c%0d_ram_wEn", c), 32'({data_wEn, tag_wEn}), 32'h0);
    end
    nextCycle();
    memDrive(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("iow_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("iow_m1_write_off", 32'(m1_write), 32'h0);
    checkOutput("iow_rsp_valid", 32'(rsp_readDataValid), 32'h0);
    nextCycle();
    cmd_valid = 1'b0;

    // IO read returning 0xDEADBEEF
    nextCycle();
    applyStimulus(4'h2, 32'h8000_0020, 1'b1, 1'b0, 4'hF, 32'h0, 2'd0);
    settle();
    nextCycle();
    settle();
    checkOutput("ior_m1_read", 32'(m1_read), 32'h1);
    checkOutput("ior_m1_address", m1_address, 32'h8000_0020);
    checkOutput("ior_m1_burst", 32'(m1_burstCount), 32'h1);
    nextCycle();
    memDrive(1'b0, 1'b1, 32'hDEAD_BEEF);
    settle();
    checkOutput("ior_wait_m1_read", 32'(m1_read), 32'h0);
    checkOutput("ior_wait_data_wEn", 32'(data_wEn), 32'h0);
    checkOutput("ior_wait_cmd_ready", 32'(cmd_ready), 32'h0);
    nextCycle();
    memDrive(1'b0, 1'b0, 32'h0);
    settle();
    checkOutput("ior_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("ior_rsp_valid", 32'(rsp_readDataValid), 32'h1);
    checkOutput("ior_rsp_data", rsp_readData, 32'hDEAD_BEEF);
    nextCycle();
    cmd_valid = 1'b0;
    settle();
    checkOutput("ior_pulse_cmd_ready", 32'(cmd_ready), 32'h0);
    checkOutput("ior_pulse_rsp_valid", 32'(rsp_readDataValid), 32'h0);

    // Reset during a refill, right as beat 1 arrives
    nextCycle();
    applyStimulus(4'h1, 32'h0000_0040, 1'b1, 1'b0, 4'hF, 32'h0, 2'd3);
    nextCycle();
    nextCycle();
    memDrive(1'b0, 1'b1, 32'hA0);
    settle();
    checkOutput("rst_b0_wEn", 32'(data_wEn), 32'h1);
    nextCycle();
    memDrive(1'b0, 1'b1, 32'hA1);
    rest = 1'b1;
    cmd_valid = 1'b0;
    settle();
    checkOutput("rst_b1_wEn", 32'(data_wEn), 32'h1);
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      rest = 1'b0;
      memDrive(1'b0, 1'b1, 32'hA2 + 32'(c));
      settle();
      checkOutput($sformatf("rst_after%0d_wEn", c), 32'(data_wEn), 32'h0);
      checkOutput($sformatf("rst_after%0d_strobes", c),
                  32'({cmd_ready, rsp_readDataValid, m1_read, m1_write, tag_wEn}), 32'h0);
      checkOutput($sformatf("rst_after%0d_rsp", c), rsp_readData, 32'h0);
    end
    nextCycle();
    memDrive(1'b0, 1'b0, 32'h0);
    applyStimulus(4'h3, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 2'd0);
    settle();
    checkOutput("hc_c0_cmd_ready", 32'(cmd_ready), 32'h0);
    nextCycle();
    settle();
    checkOutput("hc_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("hc_rsp_valid", 32'(rsp_readDataValid), 32'h0);
    nextCycle();
    cmd_valid = 1'b0;

    // Unknown command acks after two cycles without bus activity
    nextCycle();
    applyStimulus(4'h7, 32'h1234_5670, 1'b1, 1'b0, 4'hF, 32'h0, 2'd0);
    settle();
    checkOutput("unk_c0_m1", 32'({m1_read, m1_write}), 32'h0);
    nextCycle();
    settle();
    checkOutput("unk_cmd_ready", 32'(cmd_ready), 32'h1);
    checkOutput("unk_m1", 32'({m1_read, m1_write}), 32'h0);
    checkOutput("unk_rsp_valid", 32'(rsp_readDataValid), 32'h0);
    nextCycle();
    cmd_valid = 1'b0;
    settle();
    checkOutput("unk_idle_cmd_ready", 32'(cmd_ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
